fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Frame-level controller for the streaming radix-2^2 SDF FFT core.
- Gates a valid/ready sample stream into the core, which cannot stall. Aligns the core's internal counters to the frame start by driving the core's reset. Waits out the pipeline latency, then captures exactly N bit-reversed output bins with their bin index.
- Sits between the ADC sample FIFO and the spectrum result buffer; runs 1..255 back-to-back frames per start command.

Parameters:
- N, 1024, FFT length (power of 4, 16..1024).
- N_LOG2, 10, log2(N).
- INPUT_WIDTH, 14, sample width per component.
- OUTPUT_WIDTH, 25, FFT output width per component.
- ARM_CYCLES, 2, cycles the core is held in reset before a frame (>=1).
- TIMEOUT, 4096, max DRAIN cycles waiting for core sync before error.

Ports:
- clk_i  in  1  clock (same clock as FFT core clk_i).
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- frames_i  in  8  frames to run; 0 treated as 1; latched on start.
- abort_i  in  1  abort current operation.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when the last frame completes.
- err_o  out  2  sticky error flags: [0] underrun, [1] timeout; cleared on accepted start.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  sample ready (high only in LOAD).
- s_re_i, s_im_i  in  INPUT_WIDTH  sample data.
- fft_rst_n_o  out  1  reset to FFT core.
- fft_re_o, fft_im_o  out  INPUT_WIDTH  data to FFT core.
- fft_sync_i  in  1  core output-valid.
- fft_ctr_i  in  N_LOG2  core bin index.
- fft_re_i, fft_im_i  in  OUTPUT_WIDTH  core output data.
- res_valid_o  out  1  result bin valid.
- res_last_o  out  1  high with the Nth result bin of a frame.
- res_bin_o  out  N_LOG2  bin index (natural frequency order index as reported by core).
- res_re_o, res_im_o  out  OUTPUT_WIDTH  result data.

Behaviour:
- Reset values:
  - Outputs 0; fft_rst_n_o=0; state IDLE; counters 0.
  - Reset mid-operation discards the frame; no done_o.
- States and transitions:
  - IDLE: fft_rst_n_o=0. On start_i, latch frames_i, clear err_o, go to ARM.
  - ARM: fft_rst_n_o=0 for exactly ARM_CYCLES cycles, then LOAD. fft_rst_n_o rises on the same edge LOAD is entered, so core stage0 counter=0 aligns with the first LOAD cycle.
  - LOAD: exactly N cycles, one sample per cycle regardless of the handshake. s_ready_o=1.
    - If s_valid_i=1: fft_*_o = s_*_i, registered, 1-cycle latency.
    - If s_valid_i=0: drive zeros, set err_o[0], keep counting (core cannot stall).
    - After N cycles go to DRAIN.
  - DRAIN: drive zeros into the core.
    - On the first fft_sync_i=1 go to UNLOAD; that cycle's data is bin 0 of the frame and is captured.
    - If no sync within TIMEOUT cycles: set err_o[1], go to IDLE with no done_o.
  - UNLOAD: capture every cycle with fft_sync_i=1.
    - res_* = registered core outputs: res_valid_o one cycle after the core sync; res_bin_o = fft_ctr_i of that cycle.
    - Count N captures; res_last_o with the Nth.
    - After the Nth capture: decrement the frame count. If frames remain go to ARM, else go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- Abort and start:
  - abort_i in any non-IDLE state: IDLE next cycle, fft_rst_n_o=0, res_valid_o=0 from that edge, no done_o. abort_i wins over a simultaneous start_i or state transition.
  - start_i while busy: ignored.
- Data path: no arithmetic on data; widths pass through unchanged. Sample counter and capture counter are N_LOG2+1 bits; wrap not permitted.
- Throughput: one frame takes ARM_CYCLES + N + pipeline latency + N cycles; no frame overlap.

Test Plan:
- N=64, frames_i=1, ramp input 0..63 with continuous valid.
  - Required: exactly 64 res_valid_o, res_last_o on the 64th, done_o once, err_o=0.
  - Impulse at sample 0 = 1000: every bin has re=1000, im=0.
- N=64, drop s_valid_i on LOAD cycles 10..12.
  - Required: err_o[0]=1; samples 10..12 enter the core as zero; still 64 results and done_o.
- frames_i=3, continuous DC input 100.
  - Required: 3×64 results, bin 0 re=6400 each frame, other bins 0; busy_o continuously high; single done_o after frame 3.
- Tie fft_sync_i=0, TIMEOUT=200.
  - Required: err_o[1]=1 exactly 200 cycles into DRAIN, IDLE, no done_o; next start clears err_o.
- abort_i asserted at LOAD cycle 30, start_i pulsed the same cycle.
  - Required: IDLE next cycle, fft_rst_n_o=0, no results, no done_o; a subsequent start runs a clean frame.
- rst_n low during UNLOAD.
  - Required: all outputs 0 next cycle, state IDLE; start_i while busy is ignored (busy_o unaffected).

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame-level controller for a streaming SDF FFT core
module fft_frame_sequencer #(
    parameter int N            = 1024,
    parameter int N_LOG2       = 10,
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 25,
    parameter int ARM_CYCLES   = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [7:0]              frames_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              err_o,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [INPUT_WIDTH-1:0]  s_re_i,
    input  logic [INPUT_WIDTH-1:0]  s_im_i,
    output logic                    fft_rst_n_o,
    output logic [INPUT_WIDTH-1:0]  fft_re_o,
    output logic [INPUT_WIDTH-1:0]  fft_im_o,
    input  logic                    fft_sync_i,
    input  logic [N_LOG2-1:0]       fft_ctr_i,
    input  logic [OUTPUT_WIDTH-1:0] fft_re_i,
    input  logic [OUTPUT_WIDTH-1:0] fft_im_i,
    output logic                    res_valid_o,
    output logic                    res_last_o,
    output logic [N_LOG2-1:0]       res_bin_o,
    output logic [OUTPUT_WIDTH-1:0] res_re_o,
    output logic [OUTPUT_WIDTH-1:0] res_im_o
);

    // Sample/capture counters carry one extra bit so N itself is representable.
    localparam int CW = N_LOG2 + 1;
    localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] arm_cnt;
    logic [CW-1:0] smp_cnt;
    logic [CW-1:0] cap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    frames_left;

    logic start_ok;
    logic arm_end;
    logic load_end;
    logic capture;
    logic cap_last;
    logic timeout;

    assign start_ok = (state == S_IDLE) && start_i;
    assign arm_end  = (arm_cnt == AW'(ARM_CYCLES - 1));
    assign load_end = (smp_cnt == CW'(N - 1));
    // Abort suppresses the capture on the same edge so no result leaks out.
    assign capture  = ((state == S_DRAIN) || (state == S_UNLOAD)) && fft_sync_i && !abort_i;
    assign cap_last = capture && (cap_cnt == CW'(N - 1));
    assign timeout  = (state == S_DRAIN) && !fft_sync_i && (tmo_cnt == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_ARM;
            S_ARM:    if (arm_end) state_nxt = S_LOAD;
            S_LOAD:   if (load_end) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (fft_sync_i) begin
                    state_nxt = S_UNLOAD;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_UNLOAD: begin
                if (cap_last) begin
                    state_nxt = (frames_left <= 8'd1) ? S_DONE : S_ARM;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_i && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Phase counters: arm hold, load samples, drain timeout, bin captures.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            smp_cnt <= '0;
            tmo_cnt <= '0;
            cap_cnt <= '0;
        end else begin
            arm_cnt <= ((state == S_ARM) && !arm_end) ? arm_cnt + 1'b1 : '0;
            smp_cnt <= ((state == S_LOAD) && !load_end) ? smp_cnt + 1'b1 : '0;
            tmo_cnt <= (state == S_DRAIN) ? tmo_cnt + 1'b1 : '0;
            if (capture) begin
                cap_cnt <= cap_last ? '0 : cap_cnt + 1'b1;
            end else if ((state == S_IDLE) || (state == S_ARM)) begin
                cap_cnt <= '0;
            end
        end
    end

    // Frame count latched on start (0 means one frame), decremented per finished frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            frames_left <= '0;
        end else if (start_ok) begin
            frames_left <= (frames_i == 8'd0) ? 8'd1 : frames_i;
        end else if ((state == S_UNLOAD) && cap_last) begin
            frames_left <= frames_left - 8'd1;
        end
    end

    // Sticky error flags, cleared only by an accepted start.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            err_o <= '0;
        end else if (start_ok) begin
            err_o <= '0;
        end else begin
            if ((state == S_LOAD) && !s_valid_i) begin
                err_o[0] <= 1'b1;
            end
            if (timeout && !abort_i) begin
                err_o[1] <= 1'b1;
            end
        end
    end

    // Status and core control decoded from the next state so they switch with it.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            s_ready_o   <= 1'b0;
            fft_rst_n_o <= 1'b0;
        end else begin
            busy_o      <= (state_nxt != S_IDLE);
            done_o      <= (state_nxt == S_DONE);
            s_ready_o   <= (state_nxt == S_LOAD);
            fft_rst_n_o <= (state_nxt == S_LOAD) || (state_nxt == S_DRAIN) ||
                           (state_nxt == S_UNLOAD);
        end
    end

    // Core input: one sample per LOAD cycle, zeros on underrun and outside LOAD.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            fft_re_o <= '0;
            fft_im_o <= '0;
        end else if ((state == S_LOAD) && s_valid_i) begin
            fft_re_o <= s_re_i;
            fft_im_o <= s_im_i;
        end else begin
            fft_re_o <= '0;
            fft_im_o <= '0;
        end
    end

    // Result capture: registered copy of the core output on every captured sync.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            res_valid_o <= 1'b0;
            res_last_o  <= 1'b0;
            res_bin_o   <= '0;
            res_re_o    <= '0;
            res_im_o    <= '0;
        end else begin
            res_valid_o <= capture;
            res_last_o  <= cap_last;
            if (capture) begin
                res_bin_o <= fft_ctr_i;
                res_re_o  <= fft_re_i;
                res_im_o  <= fft_im_i;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for fft_frame_sequencer with a DFT core model
module tb_fft_frame_sequencer;

    localparam int TB_N     = 64;
    localparam int TB_LOG2  = 6;
    localparam int IW       = 14;
    localparam int OW       = 25;
    localparam int CORE_LAT = 12;
    localparam int P_RAMP   = 0;
    localparam int P_IMP    = 1;
    localparam int P_DC     = 2;
    localparam real PI      = 3.14159265358979;

    typedef int vec_t [TB_N];
    typedef struct {
        int bin;
        int re;
        int im;
        bit last;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [7:0]    frames_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    err_o;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [IW-1:0] s_re_i;
    logic [IW-1:0] s_im_i;
    logic          fft_rst_n_o;
    logic [IW-1:0] fft_re_o;
    logic [IW-1:0] fft_im_o;
    logic          fft_sync_i;
    logic [TB_LOG2-1:0] fft_ctr_i;
    logic [OW-1:0] fft_re_i;
    logic [OW-1:0] fft_im_i;
    logic          res_valid_o;
    logic          res_last_o;
    logic [TB_LOG2-1:0] res_bin_o;
    logic [OW-1:0] res_re_o;
    logic [OW-1:0] res_im_o;

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   res_cnt    = 0;
    int   last_cnt   = 0;
    int   done_cnt   = 0;
    int   busy_drops = 0;
    bit   watch_busy = 0;
    bit   core_nosync = 0;
    int   r0, l0, d0;
    exp_t sb_q[$];
    vec_t sb_re, sb_im;
    vec_t cin_re, cin_im, cx_re, cx_im;
    int   ccnt;
    int   kb;

    fft_frame_sequencer #(
        .N(TB_N), .N_LOG2(TB_LOG2), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .ARM_CYCLES(2), .TIMEOUT(200)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .frames_i(frames_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_re_i(s_re_i), .s_im_i(s_im_i),
        .fft_rst_n_o(fft_rst_n_o), .fft_re_o(fft_re_o), .fft_im_o(fft_im_o),
        .fft_sync_i(fft_sync_i), .fft_ctr_i(fft_ctr_i), .fft_re_i(fft_re_i),
        .fft_im_i(fft_im_i), .res_valid_o(res_valid_o), .res_last_o(res_last_o),
        .res_bin_o(res_bin_o), .res_re_o(res_re_o), .res_im_o(res_im_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < TB_LOG2; b++) begin
            if (v[b]) r = r | (1 << (TB_LOG2 - 1 - b));
        end
        return r;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic void dft(input vec_t xr, input vec_t xi, input int k,
                                output int yr, output int yi);
        real ar, ai, th, c, s;
        ar = 0.0;
        ai = 0.0;
        for (int n = 0; n < TB_N; n++) begin
            th = 2.0 * PI * real'((n * k) % TB_N) / real'(TB_N);
            c  = $cos(th);
            s  = $sin(th);
            ar = ar + real'(xr[n]) * c + real'(xi[n]) * s;
            ai = ai + real'(xi[n]) * c - real'(xr[n]) * s;
        end
        yr = rnd(ar);
        yi = rnd(ai);
    endfunction

    // Core model: one input-register cycle after reset release, N samples, fixed
    // latency, then N bins in bit-reversed order with the natural bin index.
    always @(posedge clk_i) begin
        if (!fft_rst_n_o) begin
            ccnt       <= 0;
            fft_sync_i <= 1'b0;
            fft_ctr_i  <= '0;
            fft_re_i   <= '0;
            fft_im_i   <= '0;
        end else begin
            ccnt <= ccnt + 1;
            if (ccnt >= 1 && ccnt <= TB_N) begin
                cin_re[ccnt-1] = int'($signed(fft_re_o));
                cin_im[ccnt-1] = int'($signed(fft_im_o));
                if (ccnt == TB_N) begin
                    for (int k = 0; k < TB_N; k++) dft(cin_re, cin_im, k, cx_re[k], cx_im[k]);
                end
            end
            if (!core_nosync && ccnt >= TB_N + CORE_LAT && ccnt < 2 * TB_N + CORE_LAT) begin
                kb = bitrev(ccnt - TB_N - CORE_LAT);
                fft_sync_i <= 1'b1;
                fft_ctr_i  <= TB_LOG2'(kb);
                fft_re_i   <= OW'(cx_re[kb]);
                fft_im_i   <= OW'(cx_im[kb]);
            end else begin
                fft_sync_i <= 1'b0;
                fft_re_i   <= OW'(12345);
                fft_im_i   <= OW'(-777);
            end
        end
    end

    // Monitor: pop and compare every result bin; tally pulses.
    always @(negedge clk_i) begin
        exp_t e;
        if (done_o) done_cnt++;
        if (watch_busy && !busy_o) busy_drops++;
        if (res_valid_o) begin
            res_cnt++;
            if (res_last_o) last_cnt++;
            if (sb_q.size() == 0) begin
                check("res_unexpected", res_valid_o, 0);
            end else begin
                e = sb_q.pop_front();
                check("res_bin", res_bin_o, e.bin);
                check("res_re", $signed(res_re_o), e.re);
                check("res_im", $signed(res_im_o), e.im);
                check("res_last", res_last_o, e.last);
            end
        end
    end

    task automatic snap();
        r0 = res_cnt;
        l0 = last_cnt;
        d0 = done_cnt;
    endtask

    task automatic pulse_start(input int nfr);
        frames_i = 8'(nfr);
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
    endtask

    task automatic drive_frame(input int pat, input int drop_lo, input int drop_hi,
                               input int abort_at, input bit push);
        int   k = 0;
        int   vr, vi, yr, yi;
        bit   vld;
        exp_t en;
        while (!s_ready_o && k < 300) begin
            @(negedge clk_i);
            k++;
        end
        check("load_ready", s_ready_o, 1);
        if (!s_ready_o) return;
        for (int i = 0; i < TB_N; i++) begin
            case (pat)
                P_RAMP:  begin vr = i; vi = -i; end
                P_IMP:   begin vr = (i == 0) ? 1000 : 0; vi = 0; end
                default: begin vr = 100; vi = 0; end
            endcase
            vld = !(i >= drop_lo && i <= drop_hi);
            s_valid_i = vld;
            s_re_i = vld ? IW'(vr) : IW'(777);
            s_im_i = vld ? IW'(vi) : IW'(-55);
            sb_re[i] = vld ? vr : 0;
            sb_im[i] = vld ? vi : 0;
            if (i == abort_at) begin
                abort_i = 1'b1;
                start_i = 1'b1;
                @(negedge clk_i);
                abort_i = 1'b0;
                start_i = 1'b0;
                s_valid_i = 1'b0;
                check("abort_busy", busy_o, 0);
                check("abort_fft_rst", fft_rst_n_o, 0);
                check("abort_ready", s_ready_o, 0);
                return;
            end
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        s_re_i = '0;
        s_im_i = '0;
        check("load_len", s_ready_o, 0);
        if (push) begin
            for (int j = 0; j < TB_N; j++) begin
                en.bin = bitrev(j);
                dft(sb_re, sb_im, en.bin, yr, yi);
                en.re = yr;
                en.im = yi;
                en.last = (j == TB_N - 1);
                sb_q.push_back(en);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_o && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check("done_pulse", done_o, 1);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 0);
    endtask

    task automatic frame_summary(input string tag, input int nres, input int ndone,
                                 input int err);
        repeat (3) @(negedge clk_i);
        #1;
        check({tag, "_results"}, res_cnt - r0, nres);
        check({tag, "_last"}, last_cnt - l0, nres / TB_N);
        check({tag, "_done"}, done_cnt - d0, ndone);
        check({tag, "_err"}, err_o, err);
        check({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; frames_i = '0; abort_i = 1'b0;
        s_valid_i = 1'b0; s_re_i = '0; s_im_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", s_ready_o, 0);
        check("rst_fft_rst", fft_rst_n_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        rst_n = 1'b1;
        @(negedge clk_i);

        snap();
        pulse_start(1);
        check("ramp_busy", busy_o, 1);
        drive_frame(P_RAMP, -1, -1, -1, 1);
        wait_done(500);
        frame_summary("ramp", 64, 1, 0);

        snap();
        pulse_start(0);
        drive_frame(P_IMP, -1, -1, -1, 1);
        wait_done(500);
        frame_summary("impulse", 64, 1, 0);

        snap();
        pulse_start(1);
        drive_frame(P_RAMP, 10, 12, -1, 1);
        wait_done(500);
        frame_summary("underrun", 64, 1, 1);

        snap();
        busy_drops = 0;
        pulse_start(3);
        watch_busy = 1;
        for (int f = 0; f < 3; f++) drive_frame(P_DC, -1, -1, -1, 1);
        wait_done(500);
        watch_busy = 0;
        frame_summary("multi", 192, 1, 0);
        check("multi_busy_drops", busy_drops, 0);

        snap();
        core_nosync = 1;
        pulse_start(1);
        drive_frame(P_RAMP, -1, -1, -1, 0);
        repeat (199) @(negedge clk_i);
        check("tmo_err_before", err_o, 0);
        check("tmo_busy_before", busy_o, 1);
        @(negedge clk_i);
        check("tmo_err_at", err_o, 2);
        check("tmo_busy_at", busy_o, 0);
        frame_summary("tmo", 0, 0, 2);
        core_nosync = 0;
        snap();
        pulse_start(1);
        check("tmo_err_cleared", err_o, 0);
        drive_frame(P_RAMP, -1, -1, -1, 1);
        wait_done(500);
        frame_summary("after_tmo", 64, 1, 0);

        snap();
        pulse_start(1);
        drive_frame(P_RAMP, -1, -1, 30, 0);
        repeat (150) @(negedge clk_i);
        check("abort_stays_idle", busy_o, 0);
        frame_summary("abort", 0, 0, 0);
        snap();
        pulse_start(1);
        drive_frame(P_IMP, -1, -1, -1, 1);
        wait_done(500);
        frame_summary("after_abort", 64, 1, 0);

        snap();
        pulse_start(1);
        drive_frame(P_RAMP, -1, -1, -1, 1);
        begin
            int k = 0;
            while (!res_valid_o && k < 200) begin
                @(negedge clk_i);
                k++;
            end
        end
        check("unload_reached", res_valid_o, 1);
        repeat (10) @(negedge clk_i);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_ready", s_ready_o, 0);
        check("mid_rst_fft_rst", fft_rst_n_o, 0);
        check("mid_rst_fft_re", fft_re_o, 0);
        check("mid_rst_valid", res_valid_o, 0);
        check("mid_rst_last", res_last_o, 0);
        check("mid_rst_bin", res_bin_o, 0);
        check("mid_rst_re", res_re_o, 0);
        check("mid_rst_im", res_im_o, 0);
        rst_n = 1'b1;
        sb_q.delete();
        repeat (5) @(negedge clk_i);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", busy_o, 0);

        @(negedge clk_i);
        snap();
        pulse_start(1);
        frames_i = 8'd3;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        check("busy_start_ignored", busy_o, 1);
        drive_frame(P_DC, -1, -1, -1, 1);
        wait_done(500);
        frame_summary("busy_start", 64, 1, 0);
        repeat (100) @(negedge clk_i);
        check("busy_start_single_frame", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
